// File: rtl/uart_rx.sv
// uart_rx: TL16C550 receive-side controller polling LSR, reading RBR into a one-entry valid/ready slot.
// Optional sticky {FE,PE,OE} error capture enabled by defining UART_RX_ERR_EN.
module uart_rx #(
  parameter int STROBE_CYCLES = 2,
  parameter int POLL_GAP      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       EN,
  inout  wire  [7:0] parallel_port,
  output logic       read_enable,
  output logic       write_enable,
  output logic [3:0] address,
  output logic       ADS,
  output logic [7:0] data_out,
  output logic       data_valid,
  input  logic       data_ready,
  output logic [2:0] err,
  input  logic       err_clr
);

  typedef enum logic [3:0] {
    IDLE, LSR_ADS, LSR_RD, LSR_REC,
    RBR_ADS, RBR_RD, RBR_REC, HOLD, GAP
  } state_t;

  localparam logic [3:0] STRB_LAST = 4'(STROBE_CYCLES - 1);
  localparam logic [7:0] GAP_LOAD  = 8'(POLL_GAP);

  state_t     state, state_nx;
  logic [3:0] strb_cnt;
  logic [7:0] gap_cnt;
  logic [7:0] lsr;
  logic [2:0] addr_q;
  logic       last_rd;
  logic [7:0] unused_sig;

  assign parallel_port = 8'bz;
  assign write_enable  = 1'b1;
  assign address       = {1'b0, addr_q};
  assign last_rd       = (strb_cnt == STRB_LAST);
  assign unused_sig    = {err_clr, lsr[7:1]};

  assign ADS = !(state == LSR_ADS || state == RBR_ADS);
  assign read_enable = !(state == LSR_RD || state == RBR_RD);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (EN) state_nx = LSR_ADS;
      LSR_ADS: state_nx = LSR_RD;
      LSR_RD:  if (last_rd) state_nx = LSR_REC;
      LSR_REC: begin
        if (lsr[0])            state_nx = RBR_ADS;
        else if (POLL_GAP > 0) state_nx = GAP;
        else if (EN)           state_nx = LSR_ADS;
        else                   state_nx = IDLE;
      end
      RBR_ADS: state_nx = RBR_RD;
      RBR_RD:  if (last_rd) state_nx = RBR_REC;
      RBR_REC: state_nx = HOLD;
      // A byte already taken during RBR_REC leaves nothing to wait for
      HOLD: begin
        if (!data_valid || data_ready)
          state_nx = EN ? LSR_ADS : IDLE;
      end
      GAP: begin
        if (gap_cnt == 8'd0)
          state_nx = EN ? LSR_ADS : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      strb_cnt   <= 4'd0;
      gap_cnt    <= 8'd0;
      lsr        <= 8'h00;
      addr_q     <= 3'b000;
      data_out   <= 8'h00;
      data_valid <= 1'b0;
    end else begin
      state <= state_nx;
      if (state_nx == LSR_ADS)
        addr_q <= 3'b101;
      else if (state_nx == RBR_ADS)
        addr_q <= 3'b000;
      if (state == LSR_RD || state == RBR_RD)
        strb_cnt <= strb_cnt + 4'd1;
      else
        strb_cnt <= 4'd0;
      if (state == LSR_RD && last_rd)
        lsr <= parallel_port;
      if (state == RBR_RD && last_rd) begin
        data_out   <= parallel_port;
        data_valid <= 1'b1;
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
      // GAP runs POLL_GAP+1 cycles, counting down to zero
      if (state == LSR_REC)
        gap_cnt <= GAP_LOAD;
      else if (state == GAP && gap_cnt != 8'd0)
        gap_cnt <= gap_cnt - 8'd1;
    end
  end

`ifdef UART_RX_ERR_EN
  logic [2:0] err_q;
  logic [2:0] err_new;

  assign err_new = (state == LSR_REC && lsr[0]) ?
                   {lsr[3], lsr[2], lsr[1]} : 3'b000;
  assign err = err_q;

  always_ff @(posedge clk) begin
    if (rst)
      err_q <= 3'b000;
    else
      err_q <= (err_clr ? 3'b000 : err_q) | err_new;
  end
`else
  assign err = 3'b000;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx with a queue-backed UART bus model.
// Expected err depends on whether UART_RX_ERR_EN is defined.
module tb_uart_rx;

  localparam int SC = 2;
  localparam int PG = 4;
  localparam int LAT = 2 * SC + 3;
  localparam int POLL_PER = SC + 3 + PG;
`ifdef UART_RX_ERR_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, EN, data_ready, err_clr;
  wire  [7:0] pp;
  logic read_enable, write_enable, ADS, data_valid;
  logic [3:0] address;
  logic [7:0] data_out;
  logic [2:0] err;

  always #5 clk = ~clk;

  uart_rx #(.STROBE_CYCLES(SC), .POLL_GAP(PG)) dut (
    .clk(clk), .rst(rst), .EN(EN), .parallel_port(pp),
    .read_enable(read_enable), .write_enable(write_enable),
    .address(address), .ADS(ADS), .data_out(data_out),
    .data_valid(data_valid), .data_ready(data_ready),
    .err(err), .err_clr(err_clr)
  );

  // UART model: pending bytes with the LSR value seen when each is at the head
  logic [7:0] lsr_mem [64];
  logic [7:0] rbr_mem [64];
  int wr_ptr = 0;
  int rd_ptr = 0;
  logic [7:0] bus_val;

  always_comb begin
    bus_val = 8'h00;
    if (wr_ptr != rd_ptr) begin
      if (address[2:0] == 3'd5)
        bus_val = {lsr_mem[rd_ptr[5:0]][7:1], 1'b1};
      else
        bus_val = rbr_mem[rd_ptr[5:0]];
    end
  end

  assign pp = read_enable ? 8'hzz : bus_val;

  int cyc = 0, ads_cnt = 0, rbr_ads_cnt = 0, last_lsr_ads = 0;
  int prev_ads = 0, ads_int = 0, lat = 0, dv_len = 0, dv_run = 0;
  int overlap = 0;
  logic [3:0] ads_addr = 4'h0;
  logic prev_dv = 1'b0;
  logic [7:0] got_q [$];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (!ADS) begin
      ads_cnt  <= ads_cnt + 1;
      ads_addr <= address;
      ads_int  <= cyc - prev_ads;
      prev_ads <= cyc;
      if (address[2:0] == 3'd5) last_lsr_ads <= cyc;
      if (address[2:0] == 3'd0) rbr_ads_cnt <= rbr_ads_cnt + 1;
    end
    if (!ADS && !read_enable) overlap <= overlap + 1;
    if (data_valid && !prev_dv) begin
      lat    <= cyc - last_lsr_ads;
      rd_ptr <= rd_ptr + 1;
    end
    if (data_valid) dv_run <= dv_run + 1;
    else if (prev_dv) begin
      dv_len <= dv_run;
      dv_run <= 0;
    end
    if (data_valid && data_ready) got_q.push_back(data_out);
    prev_dv <= data_valid;
  end

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] l, input logic [7:0] b);
    lsr_mem[wr_ptr[5:0]] = l;
    rbr_mem[wr_ptr[5:0]] = b;
    wr_ptr++;
  endtask

  task automatic wait_got(input int n, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (got_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic wait_ads(output bit ok);
    int a0;
    a0 = ads_cnt;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (ads_cnt != a0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
  endtask

  function automatic logic [2:0] lsr_err(input logic [7:0] l);
    return ERR_ON ? {l[3], l[2], l[1]} : 3'b000;
  endfunction

  typedef struct {
    logic [7:0] lsr;
    logic [7:0] rbr;
    logic [2:0] exp_err;
  } vec_t;

  vec_t vecs [5];

  initial begin
    bit ok, stable;
    int base, rb, a0, n;
    logic [7:0] exp_q [$];
    logic [7:0] l, b;
    logic [2:0] exp_err;

    vecs[0] = '{8'h01, 8'hA5, 3'b000};
    vecs[1] = '{8'h0B, 8'h55, 3'b101};
    vecs[2] = '{8'h03, 8'h00, 3'b001};
    vecs[3] = '{8'h61, 8'h3C, 3'b000};
    vecs[4] = '{8'h05, 8'hFF, 3'b010};

    rst = 1'b1; EN = 1'b1; data_ready = 1'b1; err_clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("ads_in_reset", ADS, 1);
    end
    check("rst_read_enable", read_enable, 1);
    check("rst_write_enable", write_enable, 1);
    check("rst_address", address, 0);
    check("rst_data_out", data_out, 0);
    check("rst_data_valid", data_valid, 0);
    check("rst_err", err, 0);
    step();
    rst = 1'b0;

    for (int v = 0; v < 5; v++) begin
      pulse_clr();
      base = got_q.size();
      rb = rbr_ads_cnt;
      push(vecs[v].lsr, vecs[v].rbr);
      wait_got(base + 1, 100, ok);
      check("vec_delivered", ok, 1);
      repeat (3) step();
      if (ok) check("vec_byte", got_q[base], vecs[v].rbr);
      check("vec_latency", lat, LAT);
      check("vec_valid_len", dv_len, 1);
      check("vec_rbr_reads", rbr_ads_cnt - rb, 1);
      check("vec_err", err, ERR_ON ? vecs[v].exp_err : 3'b000);
    end
    pulse_clr();
    step();
    check("err_cleared", err, 0);

    // Backpressure: byte held, bus quiet, poll resumes right after handshake
    data_ready = 1'b0;
    push(8'h01, 8'h3C);
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      step();
      ok = data_valid;
    end
    check("bp_valid", ok, 1);
    a0 = ads_cnt;
    stable = 1'b1;
    repeat (20) begin
      step();
      stable &= data_valid && (data_out == 8'h3C);
    end
    check("bp_hold", stable, 1);
    check("bp_no_ads", ads_cnt - a0, 0);
    base = got_q.size();
    data_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_valid_clr", data_valid, 0);
    check("bp_next_ads", ADS, 0);
    check("bp_next_addr", address, 5);
    step();
    check("bp_byte", got_q.size() > base ? got_q[base] : 8'hxx, 8'h3C);

    // Empty polling
    rb = rbr_ads_cnt;
    for (int k = 0; k < 3; k++) begin
      wait_ads(ok);
      check("poll_ads", ok, 1);
      check("poll_period", ads_int, POLL_PER);
      check("poll_addr", ads_addr, 5);
    end
    check("poll_no_rbr", rbr_ads_cnt - rb, 0);
    check("poll_no_valid", data_valid, 0);
    EN = 1'b0;
    repeat (12) step();
    a0 = ads_cnt;
    repeat (30) step();
    check("en_off_quiet", ads_cnt - a0, 0);
    check("en_off_rd", read_enable, 1);

    // Reset during RBR strobe
    EN = 1'b1;
    data_ready = 1'b0;
    push(8'h09, 8'h77);
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      ok = !read_enable && (address[2:0] == 3'd0);
    end
    check("mid_rbr_seen", ok, 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_rd", read_enable, 1);
    check("mid_rst_ads", ADS, 1);
    check("mid_rst_valid", data_valid, 0);
    check("mid_rst_err", err, 0);
    step();
    rst = 1'b0;
    wait_ads(ok);
    check("post_rst_ads", ok, 1);
    check("post_rst_lsr", ads_addr, 5);
    base = got_q.size();
    data_ready = 1'b1;
    wait_got(base + 1, 100, ok);
    check("post_rst_delivered", ok, 1);
    if (ok) check("post_rst_byte", got_q[base], 8'h77);

    // Randomized traffic against an in-order byte/OR-of-errors model
    pulse_clr();
    step();
    exp_err = 3'b000;
    base = got_q.size();
    n = 0;
    for (int i = 0; i < 400; i++) begin
      data_ready = 1'($urandom % 2);
      if (n < 24 && ($urandom % 8) == 0) begin
        l = {7'($urandom), 1'b1};
        b = 8'($urandom);
        push(l, b);
        exp_q.push_back(b);
        exp_err |= lsr_err(l);
        n++;
      end
      step();
    end
    data_ready = 1'b1;
    wait_got(base + n, 600, ok);
    check("rand_all_delivered", ok, 1);
    for (int i = 0; i < n; i++)
      if (base + i < got_q.size())
        check("rand_byte", got_q[base + i], exp_q[i]);
    step();
    check("rand_err", err, exp_err);
    check("ads_rd_overlap", overlap, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Read-side controller for the TL16C550 UART ACE. It polls the Line Status Register (LSR) over the parallel bus and, when Data Ready is set, reads the Receiver Buffer Register (RBR). It presents each received byte on a one-entry valid/ready output to downstream logic. It shares the UART bus pins and conventions with the transmit-side controller: active-low strobes, `address[3]` as DLAB, and `clk` matching the UART bridge clock.

## Interface
- `STROBE_CYCLES`, default 2: cycles `read_enable` is held low per bus read; legal range 1–15.
- `POLL_GAP`, default 4: idle cycles between LSR polls after an empty poll (DR=0); legal range 0–255.
- `clk` input 1: single clock, same clock as the UART bridge device.
- `rst` input 1: reset, synchronous, active-high.
- `EN` input 1: active high; enables polling.
- `parallel_port` inout 8: UART data bus; this block never drives it (constant `8'bz`).
- `read_enable` output 1: active-low read strobe (RD) to the UART.
- `write_enable` output 1: active-low write strobe; held high (inactive) at all times.
- `address` output 4: `[2:0]` register select, `[3]` DLAB; `[3]` is always 0.
- `ADS` output 1: address strobe, active low.
- `data_out` output 8: received byte.
- `data_valid` output 1: `data_out` holds an unconsumed byte.
- `data_ready` input 1: consumer accepts the byte when `data_valid && data_ready` at a rising edge.
- `err` output 3: sticky LSR error flags `{FE, PE, OE}`.
- `err_clr` input 1: clears `err`.

## Operation
- States: IDLE, LSR_ADS, LSR_RD, LSR_REC, RBR_ADS, RBR_RD, RBR_REC, HOLD, GAP.
- IDLE: if `EN`, go to LSR_ADS.
- LSR_ADS: `address[2:0]=3'b101`, `ADS=0`, `read_enable=1`. Lasts 1 cycle.
- LSR_RD: `ADS=1`, `read_enable=0`, address held. Lasts `STROBE_CYCLES`. `parallel_port` is captured into the internal LSR copy on the last cycle.
- LSR_REC: all strobes inactive. Next state:
  - LSR bit0 (DR)=1: RBR_ADS.
  - DR=0, `POLL_GAP`>0: GAP.
  - DR=0, `POLL_GAP`=0: LSR_ADS, or IDLE if `EN`=0.
- RBR_ADS / RBR_RD: same sequence as the LSR states, with `address[2:0]=3'b000`. On the last RD cycle, `parallel_port` loads into `data_out` and `data_valid` is set.
- RBR_REC: strobes inactive, then go to HOLD.
- HOLD: wait for `data_ready`. On handshake, clear `data_valid`, then go to LSR_ADS if `EN`, else IDLE. No bus activity while a byte is pending; the UART FIFO provides backpressure.
- GAP: count `POLL_GAP` cycles, then go to LSR_ADS if `EN`, else IDLE.
- `EN` falling mid-sequence: the current bus read and any pending HOLD complete normally, then the FSM returns to IDLE. A bus cycle is never truncated.
- `address` changes only on entry to an ADS state and holds its value otherwise.
- `err_clr` and a new error on the same cycle: the new error wins (bit set).

## Timing
- Reset values: `read_enable=1`, `write_enable=1`, `ADS=1`, `address=4'b0000`, `data_out=8'h00`, `data_valid=0`, `err=3'b000`, state IDLE, LSR copy 0, gap counter 0.
- `rst` mid-operation: strobes go inactive on the next edge. The bus cycle is aborted, and any pending byte and error flags are discarded.
- Latency with DR=1, measured from the LSR_ADS cycle (cycle 0): `data_valid` rises at cycle `2*STROBE_CYCLES+3`, which is 7 for the default.
- Full bus read occupies `STROBE_CYCLES+2` cycles. The minimum spacing between consecutive `ADS` pulses is therefore `STROBE_CYCLES+2` cycles.
- Back-to-back bytes with `data_ready` held high: the handshake cycle in HOLD is followed immediately by LSR_ADS.
- Empty-poll period: `STROBE_CYCLES+3+POLL_GAP` cycles between LSR `ADS` pulses, which is 9 for the defaults.
- `ADS` low and `read_enable` low are never asserted in the same cycle.

## Configuration
- `UART_RX_ERR_EN` defined:
  - In LSR_REC with DR=1, LSR bits 1/2/3 (OE/PE/FE) are OR-ed into `err[0]/err[1]/err[2]`.
  - `err` is sticky until `err_clr` or `rst`.
  - A byte whose LSR read shows PE or FE is still delivered.
- `UART_RX_ERR_EN` undefined: `err` is tied to `3'b000`, `err_clr` is ignored, and no error logic is synthesized.

## Test plan
- Reset: hold `rst` 3 cycles with `EN=1` -> every output at its reset value and `ADS` stays high during reset.
- Single byte: bus model returns LSR=0x01 then RBR=0xA5, `data_ready=1` -> `address` sequence 5 then 0, `data_valid` high for 1 cycle with `data_out=0xA5`, exactly 7 cycles after the first `ADS` low.
- Backpressure: 0x3C received with `data_ready=0` for 20 cycles -> `data_valid`/`data_out` held stable, no `ADS` pulses, and the next LSR poll starts the cycle after the handshake.
- Empty polling: LSR=0x00 always -> `ADS` pulses every 9 cycles, `address=5` each time, no RBR reads, `data_valid` stays 0; deassert `EN` -> returns to IDLE after the current cycle.
- Errors (`UART_RX_ERR_EN` defined): LSR=0x0B, RBR=0x55 -> byte 0x55 delivered and `err=3'b101`; pulse `err_clr` -> `err=3'b000`. Undefined: same stimulus -> `err=3'b000`.
- Reset mid-strobe: assert `rst` during RBR_RD -> `read_enable=1` next cycle, `data_valid=0`, state IDLE, and the next poll after release starts with LSR.
